// File: rtl/mac_generator.sv
// -----------------------------------------------------------------------------
// mac_generator
//   Keyed MAC stage for the encryption/decryption datapath. The data word is
//   combined with the key by bitwise XOR and registered. Alongside the MAC the
//   block registers a modulo-2^SUM_W sum of the MAC's bytes and a valid flag.
//
//   Latency is one cycle, and the block accepts a new word on every cycle
//   while enable is high. MAC and mac_sum always come from the same sampled
//   inputs.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   reset      asynchronous, active-high; clears every output immediately
//   key        WIDTH-bit secret key word
//   data       WIDTH-bit message data word
//   enable     samples key/data on this edge and produces a new MAC
//   MAC        registered data ^ key
//   mac_valid  high for exactly the cycles in which MAC is freshly computed
//   mac_sum    registered byte-sum checksum of the new MAC (wraps)
// -----------------------------------------------------------------------------
module mac_generator #(
  parameter int WIDTH = 256,  // must be a multiple of 8
  parameter int SUM_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key,
  input  logic [WIDTH-1:0] data,
  input  logic             enable,
  output logic [WIDTH-1:0] MAC,
  output logic             mac_valid,
  output logic [SUM_W-1:0] mac_sum
);

  localparam int NBYTES = WIDTH / 8;

  // Modulo-2^SUM_W sum of all bytes of a word. Overflow wraps silently
  // because the accumulator is exactly SUM_W bits wide.
  function automatic logic [SUM_W-1:0] byte_sum(input logic [WIDTH-1:0] v);
    logic [SUM_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < NBYTES; k++) begin
      acc = acc + SUM_W'(v[8*k +: 8]);
    end
    return acc;
  endfunction

  logic [WIDTH-1:0] xor_p0;
  logic [WIDTH-1:0] mac_p1_d,  mac_p1_q;
  logic [SUM_W-1:0] sum_p1_d,  sum_p1_q;
  logic             vld_p1_d,  vld_p1_q;

  // ---- stage p0: combine key and data, form checksum candidate ----
  always_comb begin
    xor_p0   = data ^ key;
    mac_p1_d = mac_p1_q;
    sum_p1_d = sum_p1_q;
    vld_p1_d = enable;
    if (enable) begin
      mac_p1_d = xor_p0;
      sum_p1_d = byte_sum(xor_p0);
    end
  end

  // ---- stage p1: registered outputs ----
  // The data registers are reset too: the outputs must read zero while reset
  // is high, and no sample may survive a reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_p1_q <= '0;
      sum_p1_q <= '0;
      vld_p1_q <= 1'b0;
    end else begin
      mac_p1_q <= mac_p1_d;
      sum_p1_q <= sum_p1_d;
      vld_p1_q <= vld_p1_d;
    end
  end

  assign MAC       = mac_p1_q;
  assign mac_sum   = sum_p1_q;
  assign mac_valid = vld_p1_q;

endmodule

// File: tb/tb_mac_generator.sv
module tb_mac_generator;

  localparam int WIDTH = 256;
  localparam int SUM_W = 8;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] key;
  logic [WIDTH-1:0] data;
  logic             enable;
  logic [WIDTH-1:0] MAC;
  logic             mac_valid;
  logic [SUM_W-1:0] mac_sum;

  mac_generator #(.WIDTH(WIDTH), .SUM_W(SUM_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .key      (key),
    .data     (data),
    .enable   (enable),
    .MAC      (MAC),
    .mac_valid(mac_valid),
    .mac_sum  (mac_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               phase;
    logic             vld;
    logic [WIDTH-1:0] mac;
    logic [SUM_W-1:0] sum;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0;
  int               passes = 0;
  int               phase  = 0;
  logic [WIDTH-1:0] model_mac = '0;
  logic [SUM_W-1:0] model_sum = '0;

  function automatic logic [SUM_W-1:0] ref_sum(input logic [WIDTH-1:0] v);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int k = 0; k < WIDTH / 8; k++) s = s + SUM_W'(v[8*k +: 8]);
    return s;
  endfunction

  task automatic chk(input string name, input int ph,
                     input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s (phase %0d): got %h required %h", name, ph, act, req);
  endtask

  // Drive one cycle of stimulus with an explicitly supplied expected result.
  task automatic drive_exp(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] d,
                           input logic en, input logic [WIDTH-1:0] e_mac,
                           input logic [SUM_W-1:0] e_sum);
    exp_t e;
    @(negedge clk);
    key = k; data = d; enable = en;
    if (en) begin
      model_mac = e_mac;
      model_sum = e_sum;
    end
    e.phase = phase; e.vld = en; e.mac = model_mac; e.sum = model_sum;
    sb_q.push_back(e);
  endtask

  // Drive one cycle, expected result from the reference model.
  task automatic drive(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] d,
                       input logic en);
    drive_exp(k, d, en, d ^ k, ref_sum(d ^ k));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mac"},   phase, MAC, '0);
    chk({tag, "_valid"}, phase, WIDTH'(mac_valid), '0);
    chk({tag, "_sum"},   phase, WIDTH'(mac_sum), '0);
  endtask

  // Monitor: one posedge after each issued vector, compare against scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("mac",   e.phase, MAC, e.mac);
        chk("valid", e.phase, WIDTH'(mac_valid), WIDTH'(e.vld));
        chk("sum",   e.phase, WIDTH'(mac_sum), WIDTH'(e.sum));
      end else if (mac_valid) begin
        checks++;
        $display("FAIL unexpected_valid (phase %0d): got 1 required 0", phase);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] pat_a;
    logic [WIDTH-1:0] pat_b;
    ones   = '1;
    reset  = 1'b0;
    enable = 1'b0;
    key    = '0;
    data   = '0;

    // Asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1 check_zero("reset_async");
    repeat (2) @(posedge clk);
    #1 check_zero("reset_held");
    @(negedge clk) reset = 1'b0;

    // Phase 1: data all-ones, key grows from LSB
    phase = 1;
    k = '0;
    drive_exp(k, ones, 1'b1, ones, 8'hE0);
    for (int i = 0; i < 255; i++) begin
      k[i] = 1'b1;
      drive(k, ones, 1'b1);
    end

    // Phase 2: data zero, key fills from MSB; ends at all-ones
    phase = 2;
    k = '0;
    drive(k, '0, 1'b1);
    for (int i = 255; i >= 0; i--) begin
      k[i] = 1'b1;
      if (i == 0) drive_exp(k, '0, 1'b1, ones, 8'hE0);
      else        drive(k, '0, 1'b1);
    end

    // Phase 3: data = 2, key = 1 then fills from LSB
    phase = 3;
    k = WIDTH'(1);
    drive_exp(k, WIDTH'(2), 1'b1, WIDTH'(3), 8'h03);
    for (int i = 1; i < 256; i++) begin
      k[i] = 1'b1;
      drive(k, WIDTH'(2), 1'b1);
    end

    // Phase 4: data = 1, key = 1 then fills from MSB
    phase = 4;
    k = WIDTH'(1);
    drive_exp(k, WIDTH'(1), 1'b1, '0, 8'h00);
    for (int i = 255; i >= 1; i--) begin
      k[i] = 1'b1;
      drive(k, WIDTH'(1), 1'b1);
    end

    // Phase 5: enable gating holds MAC/sum and drops valid
    phase = 5;
    drive_exp(WIDTH'(8'h0F), WIDTH'(8'hAA), 1'b1, WIDTH'(8'hA5), 8'hA5);
    drive({WIDTH/32{32'h1234_5678}}, ones, 1'b0);
    drive('0, {WIDTH/32{32'hDEAD_BEEF}}, 1'b0);
    drive_exp(WIDTH'(16'h0102), WIDTH'(16'h0300), 1'b1, WIDTH'(16'h0202), 8'h04);

    // Phase 6: reset mid-stream discards the in-flight sample
    phase = 6;
    @(negedge clk);
    key = {WIDTH/32{32'hCAFE_F00D}}; data = ones; enable = 1'b1;
    #2 reset = 1'b1;
    #1 check_zero("reset_mid");
    @(posedge clk);
    #1 check_zero("reset_mid_held");
    @(negedge clk);
    reset = 1'b0; enable = 1'b0;
    model_mac = '0; model_sum = '0;
    @(posedge clk);
    #1 check_zero("after_reset");

    // Checksum wrap: 32 x 0xFF mod 256
    phase = 7;
    drive_exp('0, ones, 1'b1, ones, 8'hE0);

    // Back-to-back alternating keys
    phase = 8;
    pat_a = {WIDTH/32{32'h0F0F_00FF}};
    pat_b = {WIDTH/32{32'hF0F0_0102}};
    for (int i = 0; i < 8; i++) begin
      drive((i % 2 == 0) ? pat_a : pat_b, {WIDTH/32{32'h8001_7F10}}, 1'b1);
    end
    drive_exp(WIDTH'(8'h80), WIDTH'(8'h01), 1'b1, WIDTH'(8'h81), 8'h81);
    drive('0, '0, 1'b0);

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: got %0d entries required 0", sb_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
